// File: rtl/mm_pkg.sv
// Shared constants, FSM state type and operand-address helpers for the
// 3x3 matrix-multiplier streaming controller.
package mm_pkg;

   localparam int N        = 3;
   localparam int ELEMS    = 9;
   localparam int IN_ELEMS = 18;
   localparam int OP_W     = 4;
   localparam int RES_W    = 10;

   typedef enum logic [2:0] {
      FILL,
      CLEAR,
      LOAD,
      SETTLE,
      UNLOAD,
      SEND
   } mm_state_t;

   // W occupies entries 0..8 row-major, X occupies entries 9..17 row-major.
   function automatic logic [4:0] w_addr(input logic [1:0] r, input logic [1:0] k);
      return 5'(r) * 5'd3 + 5'(k);
   endfunction

   function automatic logic [4:0] x_addr(input logic [1:0] k, input logic [1:0] c);
      return 5'(ELEMS) + 5'(k) * 5'd3 + 5'(c);
   endfunction

endpackage

// File: rtl/mm_operand_buf.sv
// 18-entry operand store: one write port, combinational read of the row of W
// and the column of X that feed accumulation step k.
module mm_operand_buf #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        k,
   output logic [DATA_W-1:0] w1,
   output logic [DATA_W-1:0] w2,
   output logic [DATA_W-1:0] w3,
   output logic [DATA_W-1:0] x1,
   output logic [DATA_W-1:0] x2,
   output logic [DATA_W-1:0] x3
);
   import mm_pkg::*;

   logic [DATA_W-1:0] mem [IN_ELEMS];

   // Contents after reset are irrelevant: every job rewrites all 18 entries.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign w1 = mem[w_addr(2'd0, k)];
   assign w2 = mem[w_addr(2'd1, k)];
   assign w3 = mem[w_addr(2'd2, k)];
   assign x1 = mem[x_addr(k, 2'd0)];
   assign x2 = mem[x_addr(k, 2'd1)];
   assign x3 = mem[x_addr(k, 2'd2)];

endmodule

// File: rtl/mm_stream_ctrl.sv
// Streams W and X into the 3x3 multiplier, runs one clear/load/unload job and
// returns the nine results of C = W*X over a valid/ready output.
module mm_stream_ctrl #(
   parameter int OP_W  = 4,
   parameter int RES_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_data,
   output logic [OP_W-1:0]  mm_w1,
   output logic [OP_W-1:0]  mm_w2,
   output logic [OP_W-1:0]  mm_w3,
   output logic [OP_W-1:0]  mm_x1,
   output logic [OP_W-1:0]  mm_x2,
   output logic [OP_W-1:0]  mm_x3,
   output logic             mm_load,
   output logic             mm_clear,
   output logic             mm_unload,
   input  logic [RES_W-1:0] mm_data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_data,
   output logic             out_last,
   output logic             busy
);
   import mm_pkg::*;

   // Both sides use plain valid/ready: a beat transfers on a rising edge where
   // valid and ready are both high; the source holds data until that edge.

   mm_state_t        state;
   mm_state_t        state_next;
   logic [4:0]       wr_ptr;
   logic [1:0]       k;
   logic [3:0]       j;
   logic [3:0]       rd_ptr;
   logic [RES_W-1:0] res_buf [ELEMS];
   logic             wr_en;
   logic             last_in;
   logic             last_res;
   logic             last_out;
   logic [OP_W-1:0]  buf_w1;
   logic [OP_W-1:0]  buf_w2;
   logic [OP_W-1:0]  buf_w3;
   logic [OP_W-1:0]  buf_x1;
   logic [OP_W-1:0]  buf_x2;
   logic [OP_W-1:0]  buf_x3;

   assign wr_en    = in_valid && (state == FILL);
   assign last_in  = (wr_ptr == 5'(IN_ELEMS - 1));
   assign last_res = (j == 4'(ELEMS - 1));
   assign last_out = (rd_ptr == 4'(ELEMS - 1));

   mm_operand_buf #(
      .DATA_W (OP_W)
   ) u_operand_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .k       (k),
      .w1      (buf_w1),
      .w2      (buf_w2),
      .w3      (buf_w3),
      .x1      (buf_x1),
      .x2      (buf_x2),
      .x3      (buf_x3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         k      <= '0;
         j      <= '0;
         rd_ptr <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_valid) begin
                  wr_ptr <= last_in ? 5'd0 : wr_ptr + 5'd1;
               end
            end
            CLEAR: k <= '0;
            LOAD: begin
               k <= k + 2'd1;
               j <= '0;
            end
            UNLOAD: begin
               j      <= j + 4'd1;
               rd_ptr <= '0;
            end
            SEND: begin
               if (out_ready) begin
                  rd_ptr <= last_out ? 4'd0 : rd_ptr + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // The multiplier advances its result index on the same edge, so edge j
   // captures C[j/3][j%3].
   always_ff @(posedge clk) begin
      if (state == UNLOAD) begin
         res_buf[j] <= mm_data_out;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      mm_clear   = 1'b0;
      mm_load    = 1'b0;
      mm_unload  = 1'b0;
      mm_w1      = '0;
      mm_w2      = '0;
      mm_w3      = '0;
      mm_x1      = '0;
      mm_x2      = '0;
      mm_x3      = '0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid && last_in) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            mm_clear   = 1'b1;
            state_next = LOAD;
         end
         LOAD: begin
            mm_load = 1'b1;
            mm_w1   = buf_w1;
            mm_w2   = buf_w2;
            mm_w3   = buf_w3;
            mm_x1   = buf_x1;
            mm_x2   = buf_x2;
            mm_x3   = buf_x3;
            if (k == 2'(N - 1)) begin
               state_next = SETTLE;
            end
         end
         SETTLE: state_next = UNLOAD;
         UNLOAD: begin
            mm_unload = 1'b1;
            if (last_res) begin
               state_next = SEND;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            out_data  = res_buf[rd_ptr];
            out_last  = last_out;
            if (out_ready && last_out) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Bench for mm_stream_ctrl with a behavioural 3x3 multiplier and a result
// scoreboard fed from bench-computed matrix products.
module tb_mm_stream_ctrl;

   localparam int OP_W  = 4;
   localparam int RES_W = 10;

   typedef int mat_t [9];

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_data;
   logic [OP_W-1:0]  mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3;
   logic             mm_load, mm_clear, mm_unload;
   logic [RES_W-1:0] mm_data_out;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_data;
   logic             out_last;
   logic             busy;

   int checks = 0;
   int errors = 0;
   bit ready_rand = 1'b0;

   logic [RES_W-1:0] exp_q [$];

   mm_stream_ctrl #(
      .OP_W  (OP_W),
      .RES_W (RES_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .mm_w1       (mm_w1),
      .mm_w2       (mm_w2),
      .mm_w3       (mm_w3),
      .mm_x1       (mm_x1),
      .mm_x2       (mm_x2),
      .mm_x3       (mm_x3),
      .mm_load     (mm_load),
      .mm_clear    (mm_clear),
      .mm_unload   (mm_unload),
      .mm_data_out (mm_data_out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------- multiplier model ----------------
   logic [RES_W-1:0] acc [9];
   int               idx = 0;

   always @(posedge clk) begin
      logic [OP_W-1:0] wb [3];
      logic [OP_W-1:0] xb [3];
      wb[0] = mm_w1; wb[1] = mm_w2; wb[2] = mm_w3;
      xb[0] = mm_x1; xb[1] = mm_x2; xb[2] = mm_x3;
      if (mm_clear) begin
         for (int i = 0; i < 9; i++) acc[i] <= '0;
         idx <= 0;
      end else begin
         if (mm_load) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  acc[r*3+c] <= acc[r*3+c] + RES_W'(int'(wb[r]) * int'(xb[c]));
         end
         if (mm_unload) idx <= idx + 1;
      end
   end

   assign mm_data_out = (idx < 9) ? acc[idx] : '0;

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- downstream ready driver ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   int               beat_cnt = 0;
   bit               held = 1'b0;
   bit               last_seen = 1'b0;
   logic [RES_W-1:0] held_data;
   logic             held_last;

   always @(negedge clk) begin
      logic [RES_W-1:0] e;
      if (!rst_n) begin
         exp_q.delete();
         beat_cnt  = 0;
         held      = 1'b0;
         last_seen = 1'b0;
      end else begin
         if (last_seen) begin
            chk("ready_after_last", {in_ready, busy}, 2'b10);
            last_seen = 1'b0;
         end
         if (held)
            chk("hold_stable", {out_valid, out_last, out_data}, {1'b1, held_last, held_data});
         if (out_valid)
            chk("in_ready_low_in_send", in_ready, 1'b0);
         if (out_valid && out_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk($sformatf("out_data_b%0d", beat_cnt), out_data, e);
               chk($sformatf("out_last_b%0d", beat_cnt), out_last, beat_cnt == 8);
            end
            last_seen = (beat_cnt == 8);
            beat_cnt  = (beat_cnt == 8) ? 0 : beat_cnt + 1;
            held      = 1'b0;
         end else if (out_valid) begin
            held      = 1'b1;
            held_data = out_data;
            held_last = out_last;
         end else begin
            held = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_expected(input mat_t w, input mat_t x);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            int s;
            s = 0;
            for (int kk = 0; kk < 3; kk++) s += w[r*3+kk] * x[kk*3+c];
            exp_q.push_back(RES_W'(s));
         end
   endtask

   task automatic feed_job(input mat_t w, input mat_t x, input int gap_pct, input bit push);
      int n;
      int guard;
      bit hs;
      n = 0;
      guard = 0;
      if (push) push_expected(w, x);
      while (n < 18 && guard < 2000) begin
         in_valid = ($urandom_range(0, 99) >= gap_pct);
         in_data  = OP_W'((n < 9) ? w[n] : x[n-9]);
         @(negedge clk);
         chk("in_ready_fill", in_ready, 1'b1);
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (hs) n++;
         guard++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      chk("feed_complete", n, 18);
   endtask

   // Cycle i is the one after the (i-1)th edge following the last input edge.
   task automatic check_strobes(input mat_t w, input mat_t x);
      for (int i = 1; i <= 15; i++) begin
         logic [5:0]  e_s;
         logic [23:0] e_o;
         int          kk;
         @(negedge clk);
         e_s = {i == 1, i >= 2 && i <= 4, i >= 6 && i <= 14, i == 15, 1'b0, 1'b1};
         chk($sformatf("strobes_c%0d", i),
             {mm_clear, mm_load, mm_unload, out_valid, in_ready, busy}, e_s);
         e_o = '0;
         if (i >= 2 && i <= 4) begin
            kk  = i - 2;
            e_o = {OP_W'(w[kk]), OP_W'(w[3+kk]), OP_W'(w[6+kk]),
                   OP_W'(x[kk*3]), OP_W'(x[kk*3+1]), OP_W'(x[kk*3+2])};
         end
         chk($sformatf("operands_c%0d", i), {mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3}, e_o);
      end
   endtask

   task automatic wait_idle(input string tag);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || !in_ready) && guard < 3000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk(tag, guard < 3000, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, {in_ready, out_valid, out_last, busy, mm_clear, mm_load, mm_unload},
          7'b1000000);
      chk({tag, "_data"}, {out_data, mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3}, 64'd0);
   endtask

   task automatic rand_mat(output mat_t m);
      for (int i = 0; i < 9; i++) m[i] = $urandom_range(0, 15);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      mat_t ident, seq, all15, ra, rb;
      int   guard;
      ident = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      seq   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      all15 = '{15, 15, 15, 15, 15, 15, 15, 15, 15};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // identity x 1..9, full rate, strobe sequence and latency
      feed_job(ident, seq, 0, 1'b1);
      check_strobes(ident, seq);
      wait_idle("job_ident_done");

      // back-to-back: saturating-magnitude products, then 1..9 x 1..9
      feed_job(all15, all15, 0, 1'b1);
      wait_idle("job_all15_done");
      feed_job(seq, seq, 0, 1'b1);
      check_strobes(seq, seq);
      wait_idle("job_seq_done");

      // stalled on both sides
      ready_rand = 1'b1;
      feed_job(seq, seq, 50, 1'b1);
      wait_idle("job_seq_stall_done");
      rand_mat(ra);
      rand_mat(rb);
      feed_job(ra, rb, 50, 1'b1);
      wait_idle("job_rand_stall_done");
      ready_rand = 1'b0;
      @(posedge clk);
      #1;

      // reset during LOAD with k=1: job discarded
      rand_mat(ra);
      feed_job(ra, seq, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("mid_load_before_reset", {mm_load, mm_w1}, {1'b1, OP_W'(ra[1])});
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_in_load");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset during SEND beat 4: remaining beats discarded
      rand_mat(ra);
      rand_mat(rb);
      feed_job(ra, rb, 0, 1'b1);
      guard = 0;
      while (beat_cnt != 4 && guard < 200) begin
         @(posedge clk);
         #2;
         guard++;
      end
      chk("reach_beat4", {out_valid, 4'(beat_cnt)}, {1'b1, 4'd4});
      rst_n = 1'b0;
      #1 check_reset_outputs("reset_in_send");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("no_stale_beat", {out_valid, busy}, 2'b00);
      @(posedge clk);
      #1;

      // clean job after the aborted ones
      rand_mat(ra);
      rand_mat(rb);
      feed_job(ra, rb, 0, 1'b1);
      check_strobes(ra, rb);
      wait_idle("job_after_reset_done");
      feed_job(seq, ident, 0, 1'b1);
      wait_idle("job_final_done");

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
